// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte-addressed register port using the 24-series EEPROM
// transaction format. Pads are synchronized to clk; bus activity is decoded from detected edges.
module i2c_slave_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter logic [7:0] PTR_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_stb,
  input  logic [7:0] rd_data,
  output logic       rd_stb,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [2:0] scl_q, sda_q;  // [1:0] synchronizer, [2] edge-detect delay
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic       rw, nack, byte_done;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_bit;

  assign sda_bit   = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      nack      <= 1'b0;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= PTR_INIT;
      wr_data   <= '0;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      if (wr_stb || rd_stb) reg_addr <= reg_addr + 8'd1;
      if (byte_done) begin
        wr_stb    <= 1'b1;
        wr_data   <= shreg;
        byte_done <= 1'b0;
      end
      if (start_det) begin
        state     <= ADDR;
        cnt       <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        byte_done <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        cnt       <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        byte_done <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WR_BYTE: begin
            if (scl_rise && cnt != 4'd8) begin
              shreg <= {shreg[6:0], sda_bit};
              cnt   <= cnt + 4'd1;
              if (state == WR_BYTE && cnt == 4'd7) byte_done <= 1'b1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= '0;
              if (state == ADDR) begin
                if (shreg[7:1] == I2C_ADDR) begin
                  state  <= ADDR_ACK;
                  sda_oe <= 1'b1;
                  rw     <= shreg[0];
                  busy   <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end else if (state == PTR) begin
                reg_addr <= shreg;
                state    <= PTR_ACK;
                sda_oe   <= 1'b1;
              end else begin
                state  <= WR_ACK;
                sda_oe <= 1'b1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              if (rw) begin
                state  <= RD_BYTE;
                rd_stb <= 1'b1;
              end else begin
                state <= PTR;
              end
            end
          end
          PTR_ACK, WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            // rd_data is taken at the end of the rd_stb cycle, so the MSB reaches
            // the pad one clk after the fall detect, still well inside SCL low.
            if (rd_stb) begin
              shreg  <= rd_data;
              sda_oe <= ~rd_data[7];
            end else if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe <= 1'b0;
                cnt    <= '0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              nack <= sda_bit;
            end else if (scl_fall) begin
              sda_oe <= 1'b0;
              if (nack) begin
                state <= WAIT_STOP;
              end else begin
                state  <= RD_BYTE;
                rd_stb <= 1'b1;
              end
            end
          end
          IDLE, WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C controller driving i2c_slave_regs, checked against a transaction-level
// pointer/register model plus a table of directed write transactions.
module tb_i2c_slave_regs;

  localparam logic [6:0] DEV    = 7'h50;
  localparam logic [7:0] P_INIT = 8'h3C;
  localparam int         H      = 12;

  logic       clk = 1'b0;
  logic       rstn;
  logic       scl_m, sda_m;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_stb, rd_stb, busy;

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic [7:0]  ptr_m = P_INIT;
  logic [15:0] wr_q[$], exp_wr[$];
  logic [7:0]  rd_q[$], exp_rd[$];
  logic        prev_stb = 1'b0;

  typedef struct {
    logic [6:0]  dev;
    logic [31:0] data;
    int unsigned nb;
    logic        exp_ack;
    logic [7:0]  exp_ptr;
  } wvec_t;
  wvec_t vec [4];

  i2c_slave_regs #(.I2C_ADDR(DEV), .PTR_INIT(P_INIT)) dut (
    .clk(clk), .rstn(rstn), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_stb(wr_stb), .rd_data(rd_data),
    .rd_stb(rd_stb), .busy(busy)
  );

  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_oe;
  assign rd_data = reg_addr ^ 8'hFF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (wr_stb) begin
        wr_q.push_back({reg_addr, wr_data});
        check("wr_stb_latency", cyc - rise_cyc, 32'd4);
      end
      if (rd_stb) begin
        rd_q.push_back(reg_addr);
        check("rd_stb_latency", cyc - fall_cyc, 32'd3);
      end
      if (wr_stb || rd_stb) begin
        check("stb_exclusive", 32'(wr_stb & rd_stb), 32'd0);
        check("stb_width", 32'(prev_stb), 32'd0);
      end
      prev_stb = wr_stb | rd_stb;
    end else begin
      prev_stb = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_scl(input logic v);
    scl_m = v;
    if (v) rise_cyc = cyc;
    else fall_cyc = cyc;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(H);
    set_scl(1'b1); tick(H);
    sda_m = 1'b0; tick(H);
    set_scl(1'b0); tick(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(H);
    set_scl(1'b1); tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(H);
    set_scl(1'b1); tick(H);
    set_scl(1'b0); tick(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(H);
    set_scl(1'b1); tick(H / 2);
    ack = ~sda_in;
    tick(H / 2);
    set_scl(1'b0); tick(2);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    sda_m = 1'b1;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      tick(H);
      set_scl(1'b1); tick(H / 2);
      d = {d[6:0], sda_in};
      tick(H / 2);
      set_scl(1'b0); tick(2);
    end
    send_bit(nack);
    sda_m = 1'b1;
  endtask

  task automatic check_queues();
    check("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check("wr_event", 32'(wr_q[i]), 32'(exp_wr[i]));
    check("rd_count", 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      check("rd_event", 32'(rd_q[i]), 32'(exp_rd[i]));
    check("pointer", 32'(reg_addr), 32'(ptr_m));
    wr_q.delete(); exp_wr.delete(); rd_q.delete(); exp_rd.delete();
  endtask

  // First byte after the address is the pointer; every later byte is a register write.
  task automatic txn_write(input logic [6:0] dev, input logic [31:0] data,
                           input int unsigned nb, input logic exp_ack);
    logic ack;
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    check("addr_ack", 32'(ack), 32'(exp_ack));
    check("busy_after_addr", 32'(busy), 32'(exp_ack));
    for (int unsigned i = 0; i < nb; i++) begin
      write_byte(data[8*i +: 8], ack);
      check("data_ack", 32'(ack), 32'(exp_ack));
      if (dev == DEV) begin
        if (i == 0) ptr_m = data[7:0];
        else begin
          exp_wr.push_back({ptr_m, data[8*i +: 8]});
          ptr_m = ptr_m + 8'd1;
        end
      end
    end
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check_queues();
  endtask

  task automatic txn_read(input int unsigned n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte({DEV, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    for (int unsigned i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check("rd_byte", 32'(d), 32'(ptr_m ^ 8'hFF));
      exp_rd.push_back(ptr_m);
      ptr_m = ptr_m + 8'd1;
    end
    tick(2);
    check("sda_released_after_nack", 32'(sda_oe), 32'd0);
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check_queues();
  endtask

  task automatic txn_abort(input logic [7:0] ptr, input logic [7:0] d,
                           input logic has_data, input int unsigned bits);
    logic ack;
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    check("abort_addr_ack", 32'(ack), 32'd1);
    write_byte(ptr, ack);
    check("abort_ptr_ack", 32'(ack), 32'd1);
    ptr_m = ptr;
    if (has_data) begin
      write_byte(d, ack);
      check("abort_data_ack", 32'(ack), 32'd1);
      exp_wr.push_back({ptr_m, d});
      ptr_m = ptr_m + 8'd1;
    end
    for (int unsigned i = 0; i < bits; i++) send_bit(1'($urandom_range(0, 1)));
    i2c_stop();
    check("abort_busy", 32'(busy), 32'd0);
    check_queues();
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    logic [6:0] dev;

    vec[0] = '{dev: 7'h50, data: 32'h005AA510, nb: 3, exp_ack: 1'b1, exp_ptr: 8'h12};
    vec[1] = '{dev: 7'h51, data: 32'h00221133, nb: 3, exp_ack: 1'b0, exp_ptr: 8'h12};
    vec[2] = '{dev: 7'h50, data: 32'hC3C2C1FE, nb: 4, exp_ack: 1'b1, exp_ptr: 8'h01};
    vec[3] = '{dev: 7'h50, data: 32'h00000080, nb: 1, exp_ack: 1'b1, exp_ptr: 8'h80};

    rstn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_rd_stb", 32'(rd_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'(P_INIT));
    rstn = 1'b1;
    tick(4);

    for (int i = 0; i < 4; i++) begin
      txn_write(vec[i].dev, vec[i].data, vec[i].nb, vec[i].exp_ack);
      check("vec_ptr", 32'(reg_addr), 32'(vec[i].exp_ptr));
    end

    // Pointer write, repeated START, 3-byte read ending in NACK.
    i2c_start();
    write_byte({DEV, 1'b0}, ack); check("rs_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h20, ack);       check("rs_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte({DEV, 1'b1}, ack); check("rs_rd_ack", 32'(ack), 32'd1);
    read_byte(1'b0, d); check("rs_byte0", 32'(d), 32'hDF);
    read_byte(1'b0, d); check("rs_byte1", 32'(d), 32'hDE);
    read_byte(1'b1, d); check("rs_byte2", 32'(d), 32'hDD);
    tick(2);
    check("rs_sda_released", 32'(sda_oe), 32'd0);
    check("rs_busy", 32'(busy), 32'd1);
    i2c_stop();
    exp_rd.push_back(8'h20); exp_rd.push_back(8'h21); exp_rd.push_back(8'h22);
    ptr_m = 8'h23;
    check_queues();

    // STOP four bits into a data byte, then a normal transaction.
    txn_abort(8'h40, 8'h99, 1'b1, 4);
    check("abort_ptr", 32'(reg_addr), 32'h41);
    txn_read(1);

    // Reset while the target pulls SDA low during a read (pointer 0x80 -> data 0x7F).
    txn_write(DEV, 32'h80, 1, 1'b1);
    i2c_start();
    write_byte({DEV, 1'b1}, ack);
    check("mr_addr_ack", 32'(ack), 32'd1);
    tick(4);
    check("mr_sda_driven", 32'(sda_oe), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mr_sda_oe", 32'(sda_oe), 32'd0);
    check("mr_reg_addr", 32'(reg_addr), 32'(P_INIT));
    check("mr_busy", 32'(busy), 32'd0);
    tick(2);
    rstn = 1'b1;
    i2c_stop();
    exp_rd.push_back(8'h80);
    ptr_m = P_INIT;
    check_queues();

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          dev = DEV;
          if ($urandom_range(0, 3) == 0) begin
            dev = 7'($urandom_range(0, 127));
            if (dev == DEV) dev = dev ^ 7'h01;
          end
          txn_write(dev, $urandom, $urandom_range(0, 4), dev == DEV);
        end
        2: txn_read($urandom_range(1, 3));
        default: txn_abort(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                           $urandom_range(1, 7));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
